// File: rtl/timer_array.sv
// timer_array: a bank of independent programmable down/up counters behind a
// simple byte-addressed register window.  Each channel owns 16 bytes:
//   +0x0 CTRL   [0] EN, [2:1] MODE, [3] IM
//   +0x4 PRESET reload value (CNT_W bits, upper bits read 0)
//   +0x8 COUNT  current counter value (read-only)
//   +0xC STATUS [0] PEND (write 1 to clear), [2:1] channel FSM state
//
// Bus access protocol: there is no handshake.  A write is any cycle with
// hit=1 and byteen!=0; it always completes on the next rising edge.  Reads
// are purely combinational from addr and have no side effects.

// One timer channel: control registers plus the IDLE/LOAD/CNT/INT sequencer.
module timer_channel #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_ctrl,
  input  logic             wr_preset,
  input  logic             wr_status,
  input  logic [31:0]      wdata,
  input  logic [3:0]       byteen,
  output logic [3:0]       ctrl_val,
  output logic [31:0]      preset_val,
  output logic [31:0]      count_val,
  output logic             pend_val,
  output logic [1:0]       state_val,
  output logic             irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             en;
  logic             im;
  logic [1:0]       mode;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             pend;
  logic             pend_set;
  logic             en_clr;
  logic             is_free;
  logic             is_reload;
  logic [31:0]      preset_merged;
  logic             unused_bits;

  // MODE 11 falls through to one-shot behaviour since neither flag is set.
  assign is_free   = (mode == 2'b10);
  assign is_reload = (mode == 2'b01);

  // Next-state and counter update; EN low always parks the channel in IDLE
  // with COUNT frozen, regardless of where the sequence was.
  always_comb begin
    state_next = state;
    count_next = count;
    pend_set   = 1'b0;
    en_clr     = 1'b0;
    if (!en) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_next = ST_LOAD;
        end
        ST_LOAD: begin
          count_next = is_free ? '0 : preset;
          state_next = ST_CNT;
        end
        ST_CNT: begin
          if (is_free) begin
            count_next = count + CNT_W'(1);
            if (count == '1) begin
              pend_set = 1'b1;
            end
          end else if (count > CNT_W'(1)) begin
            count_next = count - CNT_W'(1);
          end else begin
            count_next = '0;
            state_next = ST_INT;
          end
        end
        ST_INT: begin
          pend_set = 1'b1;
          if (is_reload) begin
            state_next = ST_LOAD;
          end else begin
            en_clr     = 1'b1;
            state_next = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // CTRL register; an explicit software write in the same cycle takes
  // precedence over the automatic EN clear at the end of a one-shot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en   <= 1'b0;
      mode <= 2'b00;
      im   <= 1'b0;
    end else if (wr_ctrl && byteen[0]) begin
      en   <= wdata[0];
      mode <= wdata[2:1];
      im   <= wdata[3];
    end else if (en_clr) begin
      en <= 1'b0;
    end
  end

  // Byte-merge of the write data onto the current PRESET value.
  always_comb begin
    preset_merged = 32'(preset);
    for (int b = 0; b < 4; b++) begin
      if (byteen[b]) begin
        preset_merged[8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  // PRESET register; bits at or above CNT_W are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      preset <= '0;
    end else if (wr_preset) begin
      preset <= preset_merged[CNT_W-1:0];
    end
  end

  // PEND flag: a hardware set in the same cycle beats a software clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= 1'b0;
    end else if (pend_set) begin
      pend <= 1'b1;
    end else if (wr_status && byteen[0] && wdata[0]) begin
      pend <= 1'b0;
    end
  end

  assign ctrl_val    = {im, mode, en};
  assign preset_val  = 32'(preset);
  assign count_val   = 32'(count);
  assign pend_val    = pend;
  assign state_val   = state;
  assign irq         = pend & im;
  assign unused_bits = ^{preset_merged, wdata};

endmodule

// Top level: address decode, write steering and read-back mux.
module timer_array #(
  parameter int          N_CH      = 2,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  input  logic [3:0]      byteen,
  output logic [31:0]     rdata,
  output logic            hit,
  output logic [N_CH-1:0] irq
);

  localparam logic [31:0] SPAN = 32'(16 * N_CH);

  logic [31:0]     offset;
  logic [3:0]      ch_idx;
  logic [1:0]      reg_idx;
  logic            wr;
  logic [N_CH-1:0] sel;
  logic [3:0]      ctrl_val   [N_CH];
  logic [31:0]     preset_val [N_CH];
  logic [31:0]     count_val  [N_CH];
  logic            pend_val   [N_CH];
  logic [1:0]      state_val  [N_CH];
  logic            unused_addr;

  // The window is at most 256 bytes, so offset[7:4] covers every channel.
  assign offset      = addr - BASE_ADDR;
  assign hit         = (addr >= BASE_ADDR) && (offset < SPAN);
  assign ch_idx      = offset[7:4];
  assign reg_idx     = addr[3:2];
  assign wr          = hit && (byteen != 4'b0000);
  assign unused_addr = ^{addr[1:0], offset[31:8], offset[3:0]};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign sel[i] = hit && (ch_idx == 4'(i));

    timer_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .wr_ctrl    (wr && sel[i] && (reg_idx == 2'd0)),
      .wr_preset  (wr && sel[i] && (reg_idx == 2'd1)),
      .wr_status  (wr && sel[i] && (reg_idx == 2'd3)),
      .wdata      (wdata),
      .byteen     (byteen),
      .ctrl_val   (ctrl_val[i]),
      .preset_val (preset_val[i]),
      .count_val  (count_val[i]),
      .pend_val   (pend_val[i]),
      .state_val  (state_val[i]),
      .irq        (irq[i])
    );
  end

  // Read mux; sel is one-hot or zero, so rdata is 0 outside the window.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel[i]) begin
        case (reg_idx)
          2'd0:    rdata = rdata | {28'd0, ctrl_val[i]};
          2'd1:    rdata = rdata | preset_val[i];
          2'd2:    rdata = rdata | count_val[i];
          default: rdata = rdata | {29'd0, state_val[i], pend_val[i]};
        endcase
      end
    end
  end

endmodule
